// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - triple-buffer slot sequencer for the DVI frame store (statistics counters under FB_STATS_EN)
module frame_buffer_ctrl #(
    parameter int x      = 1920,
    parameter int y      = 1080,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              endOfWrite,
    input  logic              endOfRead,
    output logic              ableToWrite,
    output logic              ableToRead,
    output logic [1:0]        writeIdx,
    output logic [1:0]        readIdx,
    output logic [ADDR_W-1:0] writeBase,
    output logic [ADDR_W-1:0] readBase,
    output logic              newFrame,
    output logic [CNT_W-1:0]  droppedFrames,
    output logic [CNT_W-1:0]  repeatedFrames
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(x * y);

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd0:    base_of = '0;
            2'd1:    base_of = FRAME_SIZE;
            default: base_of = FRAME_SIZE + FRAME_SIZE;
        endcase
    endfunction

    state_t      state, state_n;
    logic [1:0]  r, w, p;
    logic [1:0]  r_n, w_n, p_n;
    logic        pv, pv_n;
    logic        nf_n;
    logic        in_w, in_r, prev_w, prev_r;
    logic        ew, er;

    // Inputs are captured on one edge and acted on at the next, so a level
    // present at reset release still reads as a fresh rising edge.
    assign ew = in_w & ~prev_w;
    assign er = in_r & ~prev_r;

    // Input capture and edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_w   <= 1'b0;
            in_r   <= 1'b0;
            prev_w <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            in_w   <= endOfWrite;
            in_r   <= endOfRead;
            prev_w <= in_w;
            prev_r <= in_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RST;
        else       state <= state_n;
    end

    // Next-state and slot rotation; r, w, p stay a permutation of {0,1,2}.
    always_comb begin
        state_n = state;
        r_n     = r;
        w_n     = w;
        p_n     = p;
        pv_n    = pv;
        nf_n    = 1'b0;
        case (state)
            ST_RST: state_n = ST_IDLE;
            ST_IDLE: begin
                if (ew) begin
                    r_n     = w;
                    w_n     = p;
                    p_n     = r;
                    pv_n    = 1'b0;
                    nf_n    = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ew && er) begin
                    // Reader takes the just-finished frame; any stale pending frame is dropped.
                    r_n  = w;
                    w_n  = p;
                    p_n  = r;
                    pv_n = 1'b0;
                    nf_n = 1'b1;
                end else if (ew) begin
                    w_n  = p;
                    p_n  = w;
                    pv_n = 1'b1;
                end else if (er && pv) begin
                    r_n  = p;
                    p_n  = r;
                    pv_n = 1'b0;
                    nf_n = 1'b1;
                end
            end
            default: state_n = ST_RST;
        endcase
    end

    // Slot, base address and pulse registers, all updated together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r         <= 2'd0;
            w         <= 2'd1;
            p         <= 2'd2;
            pv        <= 1'b0;
            readBase  <= '0;
            writeBase <= FRAME_SIZE;
            newFrame  <= 1'b0;
        end else begin
            r         <= r_n;
            w         <= w_n;
            p         <= p_n;
            pv        <= pv_n;
            readBase  <= base_of(r_n);
            writeBase <= base_of(w_n);
            newFrame  <= nf_n;
        end
    end

    assign readIdx     = r;
    assign writeIdx    = w;
    assign ableToWrite = (state != ST_RST);
    assign ableToRead  = (state == ST_RUN);

`ifdef FB_STATS_EN
    logic             drop_inc, rep_inc;
    logic [CNT_W-1:0] drop_cnt, rep_cnt;

    assign drop_inc = (state == ST_RUN) && ew && pv;
    assign rep_inc  = (state == ST_RUN) && er && !ew && !pv;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            rep_cnt  <= '0;
        end else begin
            if (drop_inc && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
            if (rep_inc && (rep_cnt != {CNT_W{1'b1}}))   rep_cnt  <= rep_cnt + 1'b1;
        end
    end

    assign droppedFrames  = drop_cnt;
    assign repeatedFrames = rep_cnt;
`else
    assign droppedFrames  = '0;
    assign repeatedFrames = '0;
`endif

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Triple-buffer sequencer for the DVI frame store. Owns the assignment of the three frame slots to the write side (renderer) and read side (pixel scanout). Rotates slots on end-of-frame events so the reader always shows the newest complete frame and the writer never overwrites the slot being displayed. Exports slot indices and base addresses to the frame buffer datapath.

## Interface
Parameters:
- `x`, 1920, pixels per line.
- `y`, 1080, lines per frame.
- `CNT_W`, 16, width of statistics counters.
- `ADDR_W`, 23, width of base addresses; must satisfy 2^ADDR_W ≥ 3·x·y.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `endOfWrite`  in  1  writer finished a frame; rising edge detected.
- `endOfRead`  in  1  reader finished scanning a frame (vsync); rising edge detected.
- `ableToWrite`  out  1  writer may write slot `writeIdx`.
- `ableToRead`  out  1  slot `readIdx` holds a valid frame.
- `writeIdx`  out  2  slot assigned to the writer.
- `readIdx`  out  2  slot assigned to the reader.
- `writeBase`  out  ADDR_W  `writeIdx`·x·y.
- `readBase`  out  ADDR_W  `readIdx`·x·y.
- `newFrame`  out  1  one-cycle pulse: reader switched to a fresh slot.
- `droppedFrames`  out  CNT_W  completed frames discarded unseen.
- `repeatedFrames`  out  CNT_W  read frames with no fresh frame available.

## Operation
- Internal registers: `r`, `w`, `p` (read, write, pending slots; always a permutation of {0,1,2}), `pv` (pending slot holds a complete, unseen frame), FSM state.
- Edge detect: `ew` = `endOfWrite` & ~prev; `er` = `endOfRead` & ~prev. A level held high counts once. prev registers reset to 0.
- FSM states: RST (in reset), IDLE (no frame ever completed), RUN.
- RST → IDLE on first clock after reset deasserts.
- IDLE: `ableToWrite`=1, `ableToRead`=0. `er` ignored. On `ew`: r←w, w←p, p←r, pv←0, `newFrame` pulses, → RUN.
- RUN, `ew` only: swap w↔p; pv←1; if pv was 1, `droppedFrames`++.
- RUN, `er` only: if pv: swap r↔p, pv←0, `newFrame` pulses; else `repeatedFrames`++, indices unchanged.
- RUN, `ew` and `er` same cycle: r←w, w←p, p←r, pv←0, `newFrame` pulses; if pv was 1, `droppedFrames`++ (stale pending discarded in favour of just-finished frame).
- Invariant: r≠w at all times; writer never owns the displayed slot.
- Bases computed from next-state indices and registered with them; products use ADDR_W-wide arithmetic, no truncation for legal parameters.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values: `ableToWrite`=0, `ableToRead`=0, `readIdx`=0, `writeIdx`=1, p=2, pv=0, `readBase`=0, `writeBase`=x·y, `newFrame`=0, counters 0.
- First cycle after reset release: `ableToWrite`=1.
- Event latency: `endOfWrite`/`endOfRead` sampled high at edge N with prev low → new indices, bases, `ableToRead`, and `newFrame` visible after edge N+1.
- `newFrame` high exactly one cycle per switch.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), regardless of pending events; edge detectors cleared, so a level held high through reset release counts as a fresh edge.

## Configuration
- `FB_STATS_EN` defined: `droppedFrames`/`repeatedFrames` counters implemented as above.
- Undefined: counter registers removed; both outputs tied to 0; sequencing unchanged.

## Test plan
- Reset then idle: `readIdx`=0, `writeIdx`=1, `writeBase`=2073600, `ableToRead`=0; `endOfRead` pulse → no change, `repeatedFrames`=0.
- First `endOfWrite` in IDLE → `readIdx`=1, `writeIdx`=2, `readBase`=2073600, `ableToRead`=1, `newFrame` one pulse.
- RUN, two `endOfWrite` with no read → second increments `droppedFrames` to 1; next `endOfRead` shows the latest written slot.
- RUN, `endOfRead` with pv=0 → indices unchanged, `repeatedFrames`=1, no `newFrame`.
- Simultaneous `ew` and `er` with pv=1 → `readIdx`=old `writeIdx`, `droppedFrames`+1, pv=0; `endOfWrite` held high 10 cycles counts once.
- Reset asserted mid-RUN → outputs return to reset values without waiting for a clock; random 10k-event run checks r≠w every cycle.
